// File: rtl/agu_split_if.sv
// Bus bundle between the LSU issue stage, the translation unit, the load queue
// and the store buffer on one side and agu_split on the other.
interface agu_split_if #(
  parameter int ROB_W  = 6,
  parameter int DEST_W = 6
);
  logic              flush_i;

  logic              req_vld_i;
  logic              req_rdy_o;
  logic [ROB_W-1:0]  req_rob_i;
  logic [3:0]        req_op_i;
  logic [31:0]       req_data_i;
  logic [31:0]       req_addr_i;
  logic [DEST_W-1:0] req_dest_i;

  logic [31:0]       virt_addr_o;
  logic              virt_addr_vld_o;
  logic              is_write_o;
  logic [31:0]       translated_addr_i;
  logic [3:0]        excp_code_i;
  logic              excp_code_vld_i;
  logic              ans_vld_i;

  logic              lq_full_i;
  logic [31:0]       lq_addr_o;
  logic [2:0]        lq_ld_type_o;
  logic [DEST_W-1:0] lq_dest_o;
  logic [ROB_W-1:0]  lq_rob_o;
  logic [3:0]        lq_bm_o;
  logic              lq_split_o;
  logic              lq_part_o;
  logic              lq_valid_o;

  logic              enqueue_full_i;
  logic [29:0]       enqueue_address_o;
  logic [31:0]       enqueue_data_o;
  logic [3:0]        enqueue_bm_o;
  logic              enqueue_io_o;
  logic [ROB_W-2:0]  enqueue_rob_o;
  logic              enqueue_en_o;

  logic [29:0]       conflict_address_o;
  logic [3:0]        conflict_bm_o;

  logic [31:0]       excp_addr_o;
  logic [3:0]        excp_code_o;
  logic [ROB_W-1:0]  excp_rob_o;
  logic              excp_valid_o;

  // AGU side
  modport slave (
    input  flush_i, req_vld_i, req_rob_i, req_op_i, req_data_i, req_addr_i, req_dest_i,
    input  translated_addr_i, excp_code_i, excp_code_vld_i, ans_vld_i,
    input  lq_full_i, enqueue_full_i,
    output req_rdy_o, virt_addr_o, virt_addr_vld_o, is_write_o,
    output lq_addr_o, lq_ld_type_o, lq_dest_o, lq_rob_o, lq_bm_o, lq_split_o, lq_part_o, lq_valid_o,
    output enqueue_address_o, enqueue_data_o, enqueue_bm_o, enqueue_io_o, enqueue_rob_o, enqueue_en_o,
    output conflict_address_o, conflict_bm_o,
    output excp_addr_o, excp_code_o, excp_rob_o, excp_valid_o
  );

  // Pipeline / translation / queue side
  modport master (
    output flush_i, req_vld_i, req_rob_i, req_op_i, req_data_i, req_addr_i, req_dest_i,
    output translated_addr_i, excp_code_i, excp_code_vld_i, ans_vld_i,
    output lq_full_i, enqueue_full_i,
    input  req_rdy_o, virt_addr_o, virt_addr_vld_o, is_write_o,
    input  lq_addr_o, lq_ld_type_o, lq_dest_o, lq_rob_o, lq_bm_o, lq_split_o, lq_part_o, lq_valid_o,
    input  enqueue_address_o, enqueue_data_o, enqueue_bm_o, enqueue_io_o, enqueue_rob_o, enqueue_en_o,
    input  conflict_address_o, conflict_bm_o,
    input  excp_addr_o, excp_code_o, excp_rob_o, excp_valid_o
  );
endinterface

// File: rtl/agu_split.sv
// Load/store address-generation unit: holds one op, drives translation, routes to LQ / store buffer.
// Define AGU_MISALIGN_SPLIT_EN to split misaligned ops into two aligned parts instead of trapping.
module agu_split #(
  parameter int ROB_W  = 6,
  parameter int DEST_W = 6
) (
  input  logic      cpu_clock_i,
  input  logic      cpu_reset_i,
  agu_split_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [ROB_W-1:0]  rob_q;
  logic [3:0]        op_q;
  logic [31:0]       data_q;
  logic [31:0]       addr_q;
  logic [DEST_W-1:0] dest_q;

  logic        held, in_hi, is_store, misaligned;
  logic [3:0]  size_mask;
  logic [7:0]  wide_mask;
  logic [31:0] part_vaddr;
  logic [3:0]  part_bm;
  logic [31:0] part_data;
  logic [4:0]  shift_lo;
  logic [5:0]  shift_hi;
  logic        xlat_ok, misalign_trap;
  logic        fire, fault, part_ok, to_hi, done, accept;
  logic        ld_fire, st_fire;
  logic        split_flag, part_flag;

  assign held     = (state_q != IDLE);
  assign in_hi    = (state_q == HI);
  assign is_store = op_q[3];

  always_comb begin
    case (op_q[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  assign wide_mask  = {4'b0000, size_mask} << addr_q[1:0];
  assign misaligned = |wide_mask[7:4];

  assign part_vaddr = in_hi ? ({addr_q[31:2], 2'b00} + 32'd4) : addr_q;
  assign part_bm    = in_hi ? wide_mask[7:4] : wide_mask[3:0];

  // High part carries the bytes that spilled past the word boundary.
  assign shift_lo  = {addr_q[1:0], 3'b000};
  assign shift_hi  = 6'd32 - {1'b0, addr_q[1:0], 3'b000};
  assign part_data = in_hi ? (data_q >> shift_hi) : (data_q << shift_lo);

`ifdef AGU_MISALIGN_SPLIT_EN
  assign xlat_ok       = 1'b1;
  assign misalign_trap = 1'b0;
  assign split_flag    = misaligned;
  assign part_flag     = in_hi;
`else
  // Misaligned ops never reach translation; they trap straight from the holding register.
  assign xlat_ok       = !misaligned;
  assign misalign_trap = held & misaligned;
  assign split_flag    = 1'b0;
  assign part_flag     = 1'b0;
`endif

  assign fire    = held & xlat_ok & bus.ans_vld_i & !bus.lq_full_i & !bus.enqueue_full_i;
  assign fault   = fire & bus.excp_code_vld_i;
  assign part_ok = fire & !bus.excp_code_vld_i;
`ifdef AGU_MISALIGN_SPLIT_EN
  assign to_hi   = part_ok & !in_hi & misaligned;
`else
  assign to_hi   = 1'b0;
`endif
  assign done    = (fire & !to_hi) | misalign_trap;
  assign accept  = bus.req_vld_i & bus.req_rdy_o & !bus.flush_i;
  assign ld_fire = part_ok & !is_store;
  assign st_fire = part_ok & is_store;

  assign bus.req_rdy_o       = !held | done;
  assign bus.virt_addr_o     = part_vaddr;
  assign bus.virt_addr_vld_o = held & xlat_ok & !bus.flush_i;
  assign bus.is_write_o      = is_store;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (bus.flush_i)        state_d = IDLE;
    else if (done)          state_d = accept ? LO : IDLE;
    else if (to_hi)         state_d = HI;
    else if (!held && accept) state_d = LO;
  end

  // NOTE: state uses non-blocking assignment so all flops update together on the edge.
  always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
    if (cpu_reset_i) begin
      state_q <= IDLE;
      rob_q   <= '0;
      op_q    <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rob_q  <= bus.req_rob_i;
        op_q   <= bus.req_op_i;
        data_q <= bus.req_data_i;
        addr_q <= bus.req_addr_i;
        dest_q <= bus.req_dest_i;
      end
    end
  end

  always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
    if (cpu_reset_i) begin
      bus.lq_addr_o          <= '0;
      bus.lq_ld_type_o       <= '0;
      bus.lq_dest_o          <= '0;
      bus.lq_rob_o           <= '0;
      bus.lq_bm_o            <= '0;
      bus.lq_split_o         <= 1'b0;
      bus.lq_part_o          <= 1'b0;
      bus.lq_valid_o         <= 1'b0;
      bus.conflict_address_o <= '0;
      bus.conflict_bm_o      <= '0;
    end else if (bus.flush_i) begin
      bus.lq_valid_o <= 1'b0;
    end else if (ld_fire) begin
      bus.lq_addr_o          <= bus.translated_addr_i;
      bus.lq_ld_type_o       <= op_q[2:0];
      bus.lq_dest_o          <= dest_q;
      bus.lq_rob_o           <= rob_q;
      bus.lq_bm_o            <= part_bm;
      bus.lq_split_o         <= split_flag;
      bus.lq_part_o          <= part_flag;
      bus.lq_valid_o         <= 1'b1;
      bus.conflict_address_o <= bus.translated_addr_i[31:2];
      bus.conflict_bm_o      <= part_bm;
    end else if (!bus.lq_full_i) begin
      bus.lq_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
    if (cpu_reset_i) begin
      bus.enqueue_address_o <= '0;
      bus.enqueue_data_o    <= '0;
      bus.enqueue_bm_o      <= '0;
      bus.enqueue_io_o      <= 1'b0;
      bus.enqueue_rob_o     <= '0;
      bus.enqueue_en_o      <= 1'b0;
    end else if (bus.flush_i) begin
      bus.enqueue_en_o <= 1'b0;
    end else if (st_fire) begin
      bus.enqueue_address_o <= bus.translated_addr_i[31:2];
      bus.enqueue_data_o    <= part_data;
      bus.enqueue_bm_o      <= part_bm;
      bus.enqueue_io_o      <= bus.translated_addr_i[31];
      bus.enqueue_rob_o     <= rob_q[ROB_W-2:0];
      bus.enqueue_en_o      <= 1'b1;
    end else if (!bus.enqueue_full_i) begin
      bus.enqueue_en_o <= 1'b0;
    end
  end

  // Exceptions are single-cycle pulses; translation faults and misalign traps never coincide.
  always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
    if (cpu_reset_i) begin
      bus.excp_addr_o  <= '0;
      bus.excp_code_o  <= '0;
      bus.excp_rob_o   <= '0;
      bus.excp_valid_o <= 1'b0;
    end else if (bus.flush_i) begin
      bus.excp_valid_o <= 1'b0;
    end else if (fault || misalign_trap) begin
      bus.excp_addr_o  <= part_vaddr;
      bus.excp_code_o  <= fault ? bus.excp_code_i : (is_store ? 4'd6 : 4'd4);
      bus.excp_rob_o   <= rob_q;
      bus.excp_valid_o <= 1'b1;
    end else begin
      bus.excp_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_agu_split.sv
// Directed bench for agu_split; covers both the trapping and the splitting build.
module tb_agu_split;
  localparam int ROB_W  = 6;
  localparam int DEST_W = 6;

  logic        cpu_clock_i = 1'b0;
  logic        cpu_reset_i;
  logic [31:0] xlat_off;
  int          checks = 0;
  int          errors = 0;

  agu_split_if #(.ROB_W(ROB_W), .DEST_W(DEST_W)) bus ();

  agu_split #(.ROB_W(ROB_W), .DEST_W(DEST_W)) dut (
    .cpu_clock_i (cpu_clock_i),
    .cpu_reset_i (cpu_reset_i),
    .bus         (bus)
  );

  always #5 cpu_clock_i = ~cpu_clock_i;

  // Translation model: fixed offset added to the virtual address.
  assign bus.translated_addr_i = bus.virt_addr_o + xlat_off;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clock_i);
    #1;
  endtask

  task automatic issue(input logic [5:0] rob, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input logic [5:0] dest);
    bus.req_vld_i  = 1'b1;
    bus.req_rob_i  = rob;
    bus.req_op_i   = op;
    bus.req_addr_i = addr;
    bus.req_data_i = data;
    bus.req_dest_i = dest;
    tick();
    bus.req_vld_i  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    bus.flush_i         = 1'b0;
    bus.req_vld_i       = 1'b0;
    bus.req_rob_i       = '0;
    bus.req_op_i        = '0;
    bus.req_data_i      = '0;
    bus.req_addr_i      = '0;
    bus.req_dest_i      = '0;
    bus.excp_code_i     = '0;
    bus.excp_code_vld_i = 1'b0;
    bus.ans_vld_i       = 1'b0;
    bus.lq_full_i       = 1'b0;
    bus.enqueue_full_i  = 1'b0;
    xlat_off            = 32'h8000_0000;
    cpu_reset_i         = 1'b1;
    tick();
    tick();

    check("rst_rdy",      32'(bus.req_rdy_o), 1);
    check("rst_lq_vld",   32'(bus.lq_valid_o), 0);
    check("rst_enq_en",   32'(bus.enqueue_en_o), 0);
    check("rst_excp_vld", 32'(bus.excp_valid_o), 0);
    check("rst_lq_addr",  bus.lq_addr_o, 0);
    check("rst_enq_data", bus.enqueue_data_o, 0);
    check("rst_va_vld",   32'(bus.virt_addr_vld_o), 0);
    cpu_reset_i = 1'b0;
    tick();

    // Aligned lw at 0x1000
    issue(6'd5, 4'b0010, 32'h0000_1000, 32'h0, 6'd7);
    check("lw_va",     bus.virt_addr_o, 32'h0000_1000);
    check("lw_va_vld", 32'(bus.virt_addr_vld_o), 1);
    check("lw_is_wr",  32'(bus.is_write_o), 0);
    check("lw_rdy_held_no_ans", 32'(bus.req_rdy_o), 0);
    bus.ans_vld_i = 1'b1;
    #1;
    check("lw_rdy_final", 32'(bus.req_rdy_o), 1);
    tick();
    bus.ans_vld_i = 1'b0;
    check("lw_lq_vld",   32'(bus.lq_valid_o), 1);
    check("lw_lq_addr",  bus.lq_addr_o, 32'h8000_1000);
    check("lw_lq_bm",    32'(bus.lq_bm_o), 'b1111);
    check("lw_lq_split", 32'(bus.lq_split_o), 0);
    check("lw_lq_part",  32'(bus.lq_part_o), 0);
    check("lw_lq_rob",   32'(bus.lq_rob_o), 5);
    check("lw_lq_dest",  32'(bus.lq_dest_o), 7);
    check("lw_lq_type",  32'(bus.lq_ld_type_o), 'b010);
    check("lw_conf_adr", 32'(bus.conflict_address_o), 32'h2000_0400);
    tick();
    check("lw_lq_vld_clr", 32'(bus.lq_valid_o), 0);
    check("lw_idle_va_vld", 32'(bus.virt_addr_vld_o), 0);

    // sh at 0x2001
    issue(6'd9, 4'b1001, 32'h0000_2001, 32'h0000_ABCD, 6'd0);
    check("sh_is_wr", 32'(bus.is_write_o), 1);
    bus.ans_vld_i = 1'b1;
    tick();
    bus.ans_vld_i = 1'b0;
    check("sh_en",   32'(bus.enqueue_en_o), 1);
    check("sh_bm",   32'(bus.enqueue_bm_o), 'b0110);
    check("sh_data", bus.enqueue_data_o, 32'h00AB_CD00);
    check("sh_io",   32'(bus.enqueue_io_o), 1);
    check("sh_wadr", 32'(bus.enqueue_address_o), 32'h2000_0800);
    check("sh_rob",  32'(bus.enqueue_rob_o), 9);
    check("sh_no_lq", 32'(bus.lq_valid_o), 0);
    tick();
    check("sh_en_clr", 32'(bus.enqueue_en_o), 0);

    // Back-to-back lw then lbu with translation always ready
    bus.ans_vld_i  = 1'b1;
    issue(6'd1, 4'b0010, 32'h0000_0100, 32'h0, 6'd2);
    bus.req_vld_i  = 1'b1;
    bus.req_rob_i  = 6'd2;
    bus.req_op_i   = 4'b0100;
    bus.req_addr_i = 32'h0000_0202;
    bus.req_dest_i = 6'd3;
    #1;
    check("b2b_rdy", 32'(bus.req_rdy_o), 1);
    tick();
    bus.req_vld_i = 1'b0;
    check("b2b_a_addr", bus.lq_addr_o, 32'h8000_0100);
    check("b2b_a_rob",  32'(bus.lq_rob_o), 1);
    tick();
    bus.ans_vld_i = 1'b0;
    check("b2b_b_vld",  32'(bus.lq_valid_o), 1);
    check("b2b_b_addr", bus.lq_addr_o, 32'h8000_0202);
    check("b2b_b_bm",   32'(bus.lq_bm_o), 'b0100);
    check("b2b_b_type", 32'(bus.lq_ld_type_o), 'b100);
    check("b2b_b_cbm",  32'(bus.conflict_bm_o), 'b0100);
    tick();

    // Load-queue full stall, then valid hold while full
    issue(6'd4, 4'b0010, 32'h0000_0300, 32'h0, 6'd1);
    bus.ans_vld_i = 1'b1;
    bus.lq_full_i = 1'b1;
    tick();
    tick();
    check("stall_lq_vld", 32'(bus.lq_valid_o), 0);
    check("stall_rdy",    32'(bus.req_rdy_o), 0);
    check("stall_va_vld", 32'(bus.virt_addr_vld_o), 1);
    bus.lq_full_i = 1'b0;
    tick();
    bus.ans_vld_i = 1'b0;
    check("stall_fire_vld",  32'(bus.lq_valid_o), 1);
    check("stall_fire_addr", bus.lq_addr_o, 32'h8000_0300);
    bus.lq_full_i = 1'b1;
    tick();
    check("lq_vld_hold_full", 32'(bus.lq_valid_o), 1);
    bus.lq_full_i = 1'b0;
    tick();
    check("lq_vld_clr_nofull", 32'(bus.lq_valid_o), 0);

    // Aligned store with translation fault
    issue(6'd6, 4'b1010, 32'h0000_5000, 32'h1234_5678, 6'd0);
    bus.ans_vld_i       = 1'b1;
    bus.excp_code_vld_i = 1'b1;
    bus.excp_code_i     = 4'd13;
    tick();
    bus.ans_vld_i       = 1'b0;
    bus.excp_code_vld_i = 1'b0;
    check("xf_vld",  32'(bus.excp_valid_o), 1);
    check("xf_code", 32'(bus.excp_code_o), 13);
    check("xf_addr", bus.excp_addr_o, 32'h0000_5000);
    check("xf_rob",  32'(bus.excp_rob_o), 6);
    check("xf_no_enq", 32'(bus.enqueue_en_o), 0);
    tick();
    check("xf_pulse", 32'(bus.excp_valid_o), 0);

`ifdef AGU_MISALIGN_SPLIT_EN
    // Split sw at 0x3FFE
    issue(6'd3, 4'b1010, 32'h0000_3FFE, 32'h1122_3344, 6'd0);
    check("ssw_lo_va", bus.virt_addr_o, 32'h0000_3FFE);
    bus.ans_vld_i = 1'b1;
    tick();
    check("ssw_lo_en",   32'(bus.enqueue_en_o), 1);
    check("ssw_lo_bm",   32'(bus.enqueue_bm_o), 'b1100);
    check("ssw_lo_data", bus.enqueue_data_o, 32'h3344_0000);
    check("ssw_lo_wadr", 32'(bus.enqueue_address_o), 32'h2000_0FFF);
    check("ssw_hi_va",   bus.virt_addr_o, 32'h0000_4000);
    tick();
    bus.ans_vld_i = 1'b0;
    check("ssw_hi_en",   32'(bus.enqueue_en_o), 1);
    check("ssw_hi_bm",   32'(bus.enqueue_bm_o), 'b0011);
    check("ssw_hi_data", bus.enqueue_data_o, 32'h0000_1122);
    check("ssw_hi_wadr", 32'(bus.enqueue_address_o), 32'h2000_1000);
    tick();

    // Split lw at 0x0FFD, high part faults
    issue(6'd10, 4'b0010, 32'h0000_0FFD, 32'h0, 6'd4);
    bus.ans_vld_i = 1'b1;
    tick();
    check("slw_lo_vld",   32'(bus.lq_valid_o), 1);
    check("slw_lo_bm",    32'(bus.lq_bm_o), 'b1110);
    check("slw_lo_split", 32'(bus.lq_split_o), 1);
    check("slw_lo_part",  32'(bus.lq_part_o), 0);
    check("slw_hi_va",    bus.virt_addr_o, 32'h0000_1000);
    bus.excp_code_vld_i = 1'b1;
    bus.excp_code_i     = 4'd13;
    tick();
    bus.ans_vld_i       = 1'b0;
    bus.excp_code_vld_i = 1'b0;
    check("slw_xf_vld",  32'(bus.excp_valid_o), 1);
    check("slw_xf_addr", bus.excp_addr_o, 32'h0000_1000);
    check("slw_xf_code", 32'(bus.excp_code_o), 13);
    check("slw_xf_nolq", 32'(bus.lq_valid_o), 0);
    tick();
    check("slw_idle", 32'(bus.virt_addr_vld_o), 0);

    // Split lw stalled in HI by a full LQ, then flushed
    issue(6'd11, 4'b0010, 32'h0000_0FFD, 32'h0, 6'd5);
    bus.ans_vld_i = 1'b1;
    tick();
    check("fl_lo_vld", 32'(bus.lq_valid_o), 1);
    bus.lq_full_i = 1'b1;
    tick();
    tick();
    tick();
    check("fl_hold_vld", 32'(bus.lq_valid_o), 1);
    check("fl_hold_rdy", 32'(bus.req_rdy_o), 0);
    bus.lq_full_i = 1'b0;
    bus.flush_i   = 1'b1;
    tick();
    bus.flush_i   = 1'b0;
    bus.ans_vld_i = 1'b0;
    check("fl_rdy",    32'(bus.req_rdy_o), 1);
    check("fl_lq_vld", 32'(bus.lq_valid_o), 0);
    check("fl_va_vld", 32'(bus.virt_addr_vld_o), 0);
`else
    // Misaligned lh at 0x0003 traps without translation
    issue(6'd7, 4'b0001, 32'h0000_0003, 32'h0, 6'd2);
    check("mlh_va_vld", 32'(bus.virt_addr_vld_o), 0);
    check("mlh_no_excp_yet", 32'(bus.excp_valid_o), 0);
    tick();
    check("mlh_vld",   32'(bus.excp_valid_o), 1);
    check("mlh_code",  32'(bus.excp_code_o), 4);
    check("mlh_addr",  bus.excp_addr_o, 32'h0000_0003);
    check("mlh_rob",   32'(bus.excp_rob_o), 7);
    check("mlh_no_lq", 32'(bus.lq_valid_o), 0);
    tick();
    check("mlh_pulse", 32'(bus.excp_valid_o), 0);

    // Misaligned sw at 0x0006
    issue(6'd12, 4'b1010, 32'h0000_0006, 32'hDEAD_BEEF, 6'd0);
    tick();
    check("msw_vld",    32'(bus.excp_valid_o), 1);
    check("msw_code",   32'(bus.excp_code_o), 6);
    check("msw_addr",   bus.excp_addr_o, 32'h0000_0006);
    check("msw_no_enq", 32'(bus.enqueue_en_o), 0);
    tick();

    // Held load stalled by a full LQ, then flushed
    issue(6'd13, 4'b0010, 32'h0000_0400, 32'h0, 6'd3);
    bus.ans_vld_i = 1'b1;
    tick();
    check("fl_a_vld", 32'(bus.lq_valid_o), 1);
    bus.lq_full_i = 1'b1;
    issue(6'd14, 4'b0010, 32'h0000_0500, 32'h0, 6'd4);
    tick();
    tick();
    tick();
    check("fl_hold_vld", 32'(bus.lq_valid_o), 1);
    check("fl_hold_rdy", 32'(bus.req_rdy_o), 0);
    bus.lq_full_i = 1'b0;
    bus.flush_i   = 1'b1;
    tick();
    bus.flush_i   = 1'b0;
    bus.ans_vld_i = 1'b0;
    check("fl_rdy",     32'(bus.req_rdy_o), 1);
    check("fl_lq_vld",  32'(bus.lq_valid_o), 0);
    check("fl_va_vld",  32'(bus.virt_addr_vld_o), 0);
    check("fl_lq_addr", bus.lq_addr_o, 32'h8000_0400);
`endif

    // Flush beats a same-cycle accept
    bus.req_vld_i  = 1'b1;
    bus.req_op_i   = 4'b0010;
    bus.req_addr_i = 32'h0000_0700;
    bus.flush_i    = 1'b1;
    tick();
    bus.req_vld_i = 1'b0;
    bus.flush_i   = 1'b0;
    check("flacc_nothing_held", 32'(bus.virt_addr_vld_o), 0);

    // Asynchronous reset in the middle of an op
    issue(6'd15, 4'b0010, 32'h0000_0600, 32'h0, 6'd6);
    bus.ans_vld_i = 1'b1;
    tick();
    bus.lq_full_i = 1'b1;
    issue(6'd16, 4'b1010, 32'h0000_0800, 32'h5555_AAAA, 6'd0);
    check("mid_vld_before", 32'(bus.lq_valid_o), 1);
    #2;
    cpu_reset_i = 1'b1;
    #1;
    check("mr_lq_vld",   32'(bus.lq_valid_o), 0);
    check("mr_lq_addr",  bus.lq_addr_o, 0);
    check("mr_lq_rob",   32'(bus.lq_rob_o), 0);
    check("mr_rdy",      32'(bus.req_rdy_o), 1);
    check("mr_va_vld",   32'(bus.virt_addr_vld_o), 0);
    check("mr_conf_adr", 32'(bus.conflict_address_o), 0);
    bus.ans_vld_i = 1'b0;
    bus.lq_full_i = 1'b0;
    tick();
    cpu_reset_i = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
